keypad_scan_fifo: RTL and testbench
===================================

// Module: keypad_scan_fifo
// PURPOSE
//  Parametrised matrix-keypad scanner: ROWS x COLS, programmable column settle and press/release debounce.
//  Debounced key codes go into a FIFO; the general controller drains them with a KeyRdy/KeyRd handshake.
//  Adds buffering, overflow reporting, multi-key rejection and release debounce; sits between keypad pins and the key decoder.
// PARAMETERS
//  ROWS        4   keypad rows (RowIn width), >=1
//  COLS        4   keypad columns (ColOut width), >=2
//  SETTLE      2   cycles each column is driven before RowIn is sampled, >=1
//  DEBOUNCE    10  consecutive stable cycles to accept a press or a release, >=1
//  FIFO_DEPTH  4   key-code FIFO entries, power of 2, >=2
//  CW          $clog2(ROWS*COLS)   key_code width (derived, localparam)
// PORTS
//  clk           in   1           clock, rising edge
//  RST           in   1           synchronous reset, active-high
//  RowIn         in   ROWS        keypad rows, pulled up, low = pressed
//  ColOut        out  COLS        one-cold column drive, active column = 0
//  KeyRdy        out  1           FIFO not empty, key_code valid
//  KeyRd         in   1           pop head entry (honoured only when KeyRdy=1)
//  key_code      out  CW          FIFO head = row*COLS + col; 0 when empty
//  fifo_count    out  $clog2(FIFO_DEPTH+1)   entries held
//  overflow      out  1           sticky: a debounced key was dropped because the FIFO was full
//  ovf_clr       in   1           clears overflow (a same-cycle new drop wins; overflow stays 1)
//  key_held      out  1           high in HOLD and REL_DB states
// BEHAVIOUR
//  Reset (RST=1 at clk edge): state=SCAN, col=0, ColOut=~1 (col 0 low), all counters 0, FIFO empty,
//   KeyRdy=0, key_code=0, fifo_count=0, overflow=0, key_held=0. RST mid-debounce or mid-hold drops that key.
//  FSM states SCAN, PRESS_DB, PUSH, HOLD, REL_DB:
//   SCAN: drive col for SETTLE cycles. On the last settle cycle, sample RowIn.
//    - Exactly one row low: capture row pattern and row index, go to PRESS_DB, col frozen.
//    - All rows high: advance col (COLS-1 wraps to 0), stay in SCAN.
//    - Two or more rows low (ghost/multi-key): treat as no key and advance col.
//   PRESS_DB: each cycle RowIn==captured -> cnt+1; any mismatch -> cnt=0, back to SCAN on the same col.
//    When cnt reaches DEBOUNCE-1 with a match -> PUSH.
//   PUSH (1 cycle): write row*COLS+col to FIFO, then go to HOLD.
//    If FIFO full with no same-cycle pop: drop the code, set overflow.
//   HOLD: wait until all RowIn high, then REL_DB with cnt=0.
//   REL_DB: each cycle all rows high -> cnt+1; any row low -> back to HOLD.
//    When cnt reaches DEBOUNCE-1 -> SCAN at col+1 (wrapped). One press yields exactly one code (no auto-repeat).
//  Press latency: sample at cycle t -> PRESS_DB t+1..t+DEBOUNCE -> PUSH t+DEBOUNCE+1 -> KeyRdy=1 at t+DEBOUNCE+2.
//  FIFO: registered, first-word-fall-through. key_code shows the head whenever KeyRdy=1.
//   KeyRd&&KeyRdy pops at the edge. KeyRd while empty is ignored (no underflow, count unchanged).
//   Push and pop in the same cycle: count unchanged, both take effect. When full, the pop frees the slot
//    and the push is accepted; overflow is not set.
//   Pointers are log2(FIFO_DEPTH) bits, wrap modulo depth; full when count==FIFO_DEPTH.
//  Counters saturate and never wrap. ColOut changes only on a state/col update edge, never glitches mid-cycle.
// TESTING
//  1 Reset: RST=1 for 2 cycles with RowIn=0 -> ColOut=4'b1110, KeyRdy=0, count=0, overflow=0, stays SCAN.
//  2 Press row1/col2 (code 6), held 40 cycles, then released -> exactly one entry 6.
//    KeyRdy rises DEBOUNCE+2 cycles after the sample; KeyRd pulse -> KeyRdy=0, count=0.
//  3 Bounce: row0/col0 toggles every 3 cycles for 30 cycles, then stable -> only one code 0,
//    pushed DEBOUNCE+1 cycles after the last toggle's resample.
//  4 Rows 0 and 2 low together on col1 -> no push; scan keeps advancing; count stays 0.
//  5 Five distinct presses, no KeyRd, depth 4 -> count=4, overflow=1, codes are the first four in order.
//    ovf_clr -> overflow=0. Repeat with KeyRd asserted in the fifth PUSH cycle -> fifth code accepted, overflow=0.
//  6 Reset mid-PRESS_DB (cnt=5) and mid-HOLD -> FIFO empty, SCAN at col 0, no code pushed after reset until a fresh press.

Source files
------------

// File: rtl/keypad_scan_fifo_if.sv
// Purpose : pin-side and controller-side signal bundle for keypad_scan_fifo.
// Ports   : RowIn/ColOut face the keypad; KeyRdy/KeyRd/key_code/fifo_count,
//           overflow/ovf_clr and key_held face the general controller.
// Modports: slave = the scanner itself, master = whatever drives it.
interface keypad_scan_fifo_if #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(ROWS * COLS);
  localparam int NW = $clog2(FIFO_DEPTH + 1);

  logic [ROWS-1:0] RowIn;
  logic [COLS-1:0] ColOut;
  logic            KeyRdy;
  logic            KeyRd;
  logic [CW-1:0]   key_code;
  logic [NW-1:0]   fifo_count;
  logic            overflow;
  logic            ovf_clr;
  logic            key_held;

  modport slave (
    input  RowIn, KeyRd, ovf_clr,
    output ColOut, KeyRdy, key_code, fifo_count, overflow, key_held
  );

  modport master (
    output RowIn, KeyRd, ovf_clr,
    input  ColOut, KeyRdy, key_code, fifo_count, overflow, key_held
  );
endinterface

// File: rtl/keypad_scan_fifo.sv
// Purpose : ROWS x COLS keypad scanner with press/release debounce, feeding a FWFT key-code FIFO.
// Latency : row sample at cycle t -> code written at end of cycle t+DEBOUNCE+1 -> KeyRdy at t+DEBOUNCE+2.
// Backpr. : codes arriving while the FIFO is full (and not popped that cycle) are dropped; overflow goes sticky.
// Ports   : clk, RST (sync, active-high); bus (slave modport): RowIn in, ColOut out (one-cold),
//           KeyRdy/KeyRd/key_code pop handshake, fifo_count, overflow/ovf_clr, key_held.
module keypad_scan_fifo #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SETTLE     = 2,
  parameter int DEBOUNCE   = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              RST,
  keypad_scan_fifo_if.slave bus
);
  localparam int CW  = $clog2(ROWS * COLS);
  localparam int NW  = $clog2(FIFO_DEPTH + 1);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CLW = $clog2(COLS);
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int SW  = $clog2(SETTLE + 1);
  localparam int DW  = $clog2(DEBOUNCE + 1);

  typedef enum logic [2:0] {SCAN, PRESS_DB, PUSH, HOLD, REL_DB} state_t;

  state_t          state_q, state_d;
  logic [CLW-1:0]  col_q, col_d, col_inc;
  logic [SW-1:0]   settle_q, settle_d;
  logic [DW-1:0]   db_q, db_d;
  logic [ROWS-1:0] pat_q, pat_d;
  logic [RW-1:0]   idx_q, idx_d;
  logic [COLS-1:0] col_out_q;
  logic            push_req;

  // Row decode: low_cnt saturates at 2, which is all we need to tell 0 / 1 / many.
  logic [1:0]      low_cnt;
  logic [RW-1:0]   low_idx;
  logic            single_low, all_high;

  always_comb begin
    low_cnt = '0;
    low_idx = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (!bus.RowIn[r]) begin
        if (low_cnt != 2'd2) low_cnt = low_cnt + 2'd1;
        low_idx = RW'(r);
      end
    end
  end

  assign single_low = (low_cnt == 2'd1);
  assign all_high   = &bus.RowIn;
  assign col_inc    = (col_q == CLW'(COLS - 1)) ? '0 : col_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    settle_d = settle_q;
    db_d     = db_q;
    pat_d    = pat_q;
    idx_d    = idx_q;
    push_req = 1'b0;
    case (state_q)
      SCAN: begin
        if (settle_q == SW'(SETTLE - 1)) begin
          settle_d = '0;
          if (single_low) begin
            // Column stays frozen while the press is debounced.
            state_d = PRESS_DB;
            db_d    = '0;
            pat_d   = bus.RowIn;
            idx_d   = low_idx;
          end else begin
            // No key, or a ghost/multi-key pattern: move on.
            col_d = col_inc;
          end
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      PRESS_DB: begin
        if (bus.RowIn == pat_q) begin
          if (db_q == DW'(DEBOUNCE - 1)) state_d = PUSH;
          else                           db_d    = db_q + 1'b1;
        end else begin
          state_d  = SCAN;
          db_d     = '0;
          settle_d = '0;
        end
      end
      PUSH: begin
        push_req = 1'b1;
        state_d  = HOLD;
        db_d     = '0;
      end
      HOLD: begin
        if (all_high) begin
          state_d = REL_DB;
          db_d    = '0;
        end
      end
      REL_DB: begin
        if (!all_high) begin
          state_d = HOLD;
        end else if (db_q == DW'(DEBOUNCE - 1)) begin
          state_d  = SCAN;
          col_d    = col_inc;
          settle_d = '0;
          db_d     = '0;
        end else begin
          db_d = db_q + 1'b1;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q   <= SCAN;
      col_q     <= '0;
      settle_q  <= '0;
      db_q      <= '0;
      pat_q     <= '0;
      idx_q     <= '0;
      col_out_q <= ~COLS'(1);
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      settle_q  <= settle_d;
      db_q      <= db_d;
      pat_q     <= pat_d;
      idx_q     <= idx_d;
      // Registered decode of the next column so the pins never glitch.
      col_out_q <= ~(COLS'(1) << col_d);
    end
  end

  // Key-code FIFO, first-word-fall-through.
  logic [CW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [NW-1:0] cnt_q;
  logic          ovf_q;
  logic          fifo_full, fifo_empty, pop, push, drop;
  logic [CW-1:0] code;

  assign code       = CW'(int'(idx_q) * COLS + int'(col_q));
  assign fifo_full  = (cnt_q == NW'(FIFO_DEPTH));
  assign fifo_empty = (cnt_q == '0);
  assign pop        = bus.KeyRd && !fifo_empty;
  // A same-cycle pop frees the slot, so a full FIFO still accepts the push.
  assign push       = push_req && (!fifo_full || pop);
  assign drop       = push_req && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= code;
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      // A new drop in the same cycle beats the clear.
      if (drop)              ovf_q <= 1'b1;
      else if (bus.ovf_clr)  ovf_q <= 1'b0;
    end
  end

  assign bus.ColOut     = col_out_q;
  assign bus.KeyRdy     = !fifo_empty;
  assign bus.key_code   = fifo_empty ? '0 : mem[rd_q];
  assign bus.fifo_count = cnt_q;
  assign bus.overflow   = ovf_q;
  assign bus.key_held   = (state_q == HOLD) || (state_q == REL_DB);
endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Purpose : directed bench for keypad_scan_fifo with a keypad model that closes
//           the ColOut -> RowIn loop (a pressed key pulls its row low while its column is driven).
// Timing  : inputs change and outputs are sampled 1ns after each rising edge.
module tb_keypad_scan_fifo;
  localparam int ROWS = 4, COLS = 4, SETTLE = 2, DEBOUNCE = 10, FIFO_DEPTH = 4;

  logic clk = 1'b0;
  logic RST;
  always #5 clk = ~clk;

  keypad_scan_fifo_if #(.ROWS(ROWS), .COLS(COLS), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

  keypad_scan_fifo #(
    .ROWS(ROWS), .COLS(COLS), .SETTLE(SETTLE), .DEBOUNCE(DEBOUNCE), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .RST(RST),
    .bus(bus)
  );

  logic [ROWS*COLS-1:0] keys;
  logic                 force_en;
  logic [ROWS-1:0]      force_val;

  always_comb begin
    bus.RowIn = '1;
    if (force_en) begin
      bus.RowIn = force_val;
    end else begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          if (keys[r*COLS + c] && !bus.ColOut[c]) bus.RowIn[r] = 1'b0;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_held(input logic val, input int max, input string tag);
    int n;
    n = 0;
    while (bus.key_held !== val && n < max) begin
      tick();
      n++;
    end
    check(tag, {31'd0, bus.key_held}, {31'd0, val});
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic press_release(input int r, input int c, input string tag);
    keys[r*COLS + c] = 1'b1;
    wait_held(1'b1, 100, tag);
    keys = '0;
    wait_held(1'b0, 100, tag);
  endtask

  task automatic pop_check(input logic [31:0] exp, input string tag);
    check(tag, bus.key_code, exp);
    bus.KeyRd = 1'b1;
    tick();
    bus.KeyRd = 1'b0;
  endtask

  int rr [5] = '{0, 1, 2, 3, 3};
  int cc [5] = '{1, 3, 0, 2, 3};
  int ex [5] = '{1, 7, 8, 14, 15};

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    keys        = '0;
    force_en    = 1'b0;
    force_val   = '1;
    bus.KeyRd   = 1'b0;
    bus.ovf_clr = 1'b0;
    RST         = 1'b0;

    // 1: reset with every row forced low
    force_en  = 1'b1;
    force_val = '0;
    do_reset();
    check("t1_colout",   bus.ColOut, 4'b1110);
    check("t1_keyrdy",   bus.KeyRdy, 0);
    check("t1_count",    bus.fifo_count, 0);
    check("t1_overflow", bus.overflow, 0);
    check("t1_held",     bus.key_held, 0);
    check("t1_code",     bus.key_code, 0);
    force_en = 1'b0;

    // 2: single press row1/col2 -> code 6; sampled at the edge 6 after reset
    do_reset();
    keys[1*COLS + 2] = 1'b1;
    ticks(4);
    check("t2_col2", bus.ColOut, 4'b1011);
    ticks(2);
    check("t2_frozen", bus.ColOut, 4'b1011);
    ticks(10);
    check("t2_rdy_early", bus.KeyRdy, 0);
    tick();
    check("t2_rdy",   bus.KeyRdy, 1);
    check("t2_code",  bus.key_code, 6);
    check("t2_count", bus.fifo_count, 1);
    check("t2_held",  bus.key_held, 1);
    ticks(40);
    check("t2_norepeat", bus.fifo_count, 1);
    keys = '0;
    wait_held(1'b0, 50, "t2_release");
    check("t2_count_rel", bus.fifo_count, 1);
    check("t2_code_rel",  bus.key_code, 6);
    bus.KeyRd = 1'b1;
    tick();
    bus.KeyRd = 1'b0;
    check("t2_pop_rdy",   bus.KeyRdy, 0);
    check("t2_pop_count", bus.fifo_count, 0);
    check("t2_pop_code",  bus.key_code, 0);
    bus.KeyRd = 1'b1;
    tick();
    bus.KeyRd = 1'b0;
    check("t2_underflow", bus.fifo_count, 0);

    // 3: bounce on row0/col0; final resample at edge 38 -> KeyRdy after edge 49
    do_reset();
    for (int i = 0; i < 30; i++) begin
      keys[0] = (((i / 3) % 2) == 0);
      tick();
    end
    check("t3_bounce_quiet", bus.fifo_count, 0);
    keys[0] = 1'b1;
    ticks(18);
    check("t3_not_yet", bus.fifo_count, 0);
    tick();
    check("t3_rdy",   bus.KeyRdy, 1);
    check("t3_code",  bus.key_code, 0);
    check("t3_count", bus.fifo_count, 1);
    keys = '0;
    wait_held(1'b0, 50, "t3_release");
    check("t3_single", bus.fifo_count, 1);

    // 4: rows 0 and 2 on col1 -> rejected, scan keeps moving
    do_reset();
    keys[0*COLS + 1] = 1'b1;
    keys[2*COLS + 1] = 1'b1;
    ticks(2);
    check("t4_col1", bus.ColOut, 4'b1101);
    ticks(2);
    check("t4_advance", bus.ColOut, 4'b1011);
    ticks(8);
    check("t4_wrap", bus.ColOut, 4'b1011);
    ticks(20);
    check("t4_count", bus.fifo_count, 0);
    check("t4_rdy",   bus.KeyRdy, 0);
    check("t4_held",  bus.key_held, 0);
    keys = '0;

    // 5a: five presses into a depth-4 FIFO, no reads
    do_reset();
    for (int i = 0; i < 5; i++) press_release(rr[i], cc[i], "t5a_press");
    check("t5a_count", bus.fifo_count, 4);
    check("t5a_ovf",   bus.overflow, 1);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    check("t5a_ovf_clr",  bus.overflow, 0);
    check("t5a_count_cl", bus.fifo_count, 4);
    for (int i = 0; i < 4; i++) pop_check(ex[i], "t5a_order");
    check("t5a_empty", bus.fifo_count, 0);

    // 5b: same, but the fifth PUSH cycle carries a pop
    do_reset();
    for (int i = 0; i < 4; i++) press_release(rr[i], cc[i], "t5b_press");
    check("t5b_full", bus.fifo_count, 4);
    keys[3*COLS + 3] = 1'b1;
    ticks(12);
    check("t5b_push_cycle", bus.key_held, 0);
    bus.KeyRd = 1'b1;
    tick();
    bus.KeyRd = 1'b0;
    check("t5b_count", bus.fifo_count, 4);
    check("t5b_ovf",   bus.overflow, 0);
    check("t5b_held",  bus.key_held, 1);
    keys = '0;
    wait_held(1'b0, 50, "t5b_release");
    for (int i = 1; i < 5; i++) pop_check(ex[i], "t5b_order");
    check("t5b_empty", bus.fifo_count, 0);

    // 6: reset in the middle of press debounce (cnt=5) and in the middle of hold
    do_reset();
    keys[1*COLS + 2] = 1'b1;
    ticks(11);
    RST  = 1'b1;
    keys = '0;
    tick();
    RST = 1'b0;
    check("t6a_col",   bus.ColOut, 4'b1110);
    check("t6a_rdy",   bus.KeyRdy, 0);
    check("t6a_count", bus.fifo_count, 0);
    check("t6a_held",  bus.key_held, 0);
    ticks(30);
    check("t6a_nopush", bus.fifo_count, 0);
    keys[1*COLS + 2] = 1'b1;
    wait_held(1'b1, 100, "t6b_hold");
    check("t6b_count_pre", bus.fifo_count, 1);
    RST  = 1'b1;
    keys = '0;
    tick();
    RST = 1'b0;
    check("t6b_col",   bus.ColOut, 4'b1110);
    check("t6b_count", bus.fifo_count, 0);
    check("t6b_rdy",   bus.KeyRdy, 0);
    check("t6b_held",  bus.key_held, 0);
    ticks(30);
    check("t6b_nopush", bus.fifo_count, 0);
    press_release(0, 3, "t6c_fresh");
    check("t6c_count", bus.fifo_count, 1);
    check("t6c_code",  bus.key_code, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
